// File: rtl/ppb_pkg.sv
// Shared types and default sizes for the PPB serial link.
package ppb_pkg;

  localparam int unsigned PPB_N_OUT = 120;
  localparam int unsigned PPB_N_IN  = 60;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StShift = 2'd2,
    StLatch = 2'd3
  } ppb_state_t;

endpackage

// File: rtl/ppb_clk_div.sv
// Half-period tick generator: counts 0..CLK_DIV-1 and ticks on the last count.
module ppb_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  // Free-running divider, held at zero while cleared so a frame starts on a clean phase
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/ppb_shift_link.sv
// Frame engine: snapshots device_outputs, shifts it to a 595 chain while
// capturing the 165 chain into device_inputs.
module ppb_shift_link
  import ppb_pkg::*;
#(
  parameter int unsigned N_OUT   = PPB_N_OUT,
  parameter int unsigned N_IN    = PPB_N_IN,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [0:N_OUT-1] device_outputs,
  output logic [0:N_IN-1]  device_inputs,
  output logic             ser_clk,
  output logic             ser_dout,
  input  logic             ser_din,
  output logic             ser_latch,
  output logic             ser_load_n,
  output logic             busy,
  output logic             frame_done
);

  if (N_IN > N_OUT || N_IN < 2) begin : g_bad_n_in
    $error("ppb_shift_link: N_IN must be in 2..N_OUT");
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("ppb_shift_link: CLK_DIV must be at least 2");
  end

  localparam int unsigned CntW = $clog2(N_OUT + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(N_OUT - 1);
  localparam logic [CntW-1:0] InBits  = CntW'(N_IN);

  ppb_state_t       state_q, state_d;
  logic             tick;
  logic             div_clear;
  logic             phase_q;   // 0: low half of ser_clk, 1: high half
  logic             rise_q;    // first cycle with ser_clk high
  logic [CntW-1:0]  bit_cnt_q;
  logic [0:N_OUT-1] out_shift_q;
  logic [0:N_IN-1]  in_shift_q;
  logic             start;
  logic             bit_end;
  logic             last_bit;

  assign div_clear = (state_q == StIdle);
  assign start     = (state_q == StIdle) && enable;
  assign bit_end   = (state_q == StShift) && tick && phase_q;
  assign last_bit  = bit_end && (bit_cnt_q == LastBit);

  ppb_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk   (clk),
    .reset (reset),
    .clear (div_clear),
    .tick  (tick)
  );

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable)   state_d = StLoad;
      StLoad:  if (tick)     state_d = StShift;
      StShift: if (last_bit) state_d = StLatch;
      StLatch: if (tick)     state_d = StIdle;
      default:               state_d = StIdle;
    endcase
  end

  // State, counters and both shift registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      phase_q       <= 1'b0;
      rise_q        <= 1'b0;
      bit_cnt_q     <= '0;
      out_shift_q   <= '0;
      in_shift_q    <= '0;
      device_inputs <= '0;
    end else begin
      state_q <= state_d;
      rise_q  <= (state_q == StShift) && tick && !phase_q;
      if (start) begin
        out_shift_q <= device_outputs;
        bit_cnt_q   <= '0;
        phase_q     <= 1'b0;
      end else if ((state_q == StShift) && tick) begin
        phase_q <= ~phase_q;
        // Advance the out bit only at the end of the high half so ser_dout
        // changes together with the falling ser_clk.
        if (phase_q) begin
          out_shift_q <= {1'b0, out_shift_q[0:N_OUT-2]};
          bit_cnt_q   <= bit_cnt_q + 1'b1;
        end
      end
      // After N_IN samples, sample k has reached index k; later samples are dropped
      if (rise_q && (bit_cnt_q < InBits)) begin
        in_shift_q <= {in_shift_q[1:N_IN-1], ser_din};
      end
      if (frame_done) begin
        device_inputs <= in_shift_q;
      end
    end
  end

  // Pin decode from registered state
  always_comb begin
    busy       = (state_q != StIdle);
    ser_clk    = (state_q == StShift) && phase_q;
    ser_dout   = (state_q == StShift) ? out_shift_q[N_OUT-1] : 1'b0;
    ser_latch  = (state_q == StLatch);
    ser_load_n = (state_q != StLoad);
    frame_done = (state_q == StLatch) && tick;
  end

endmodule

// File: tb/tb_ppb_shift_link.sv
// Self-checking bench for ppb_shift_link with 595/165 chain models.
module tb_ppb_shift_link;
  import ppb_pkg::*;

  localparam int unsigned N_OUT   = PPB_N_OUT;
  localparam int unsigned N_IN    = PPB_N_IN;
  localparam int unsigned CLK_DIV = 4;
  localparam int FRAME_LEN = CLK_DIV * (2 * N_OUT + 2);

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [0:N_OUT-1] device_outputs;
  logic [0:N_IN-1]  device_inputs;
  logic             ser_clk, ser_dout, ser_din, ser_latch, ser_load_n, busy, frame_done;

  ppb_shift_link #(
    .N_OUT   (N_OUT),
    .N_IN    (N_IN),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .device_outputs (device_outputs),
    .device_inputs  (device_inputs),
    .ser_clk        (ser_clk),
    .ser_dout       (ser_dout),
    .ser_din        (ser_din),
    .ser_latch      (ser_latch),
    .ser_load_n     (ser_load_n),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Chain models and protocol observers, sampled on the falling clk edge
  logic [0:N_IN-1] pat = '0;
  bit              stream[$];
  int              rises = 0, falls = 0, load_cyc = 0, latch_cyc = 0;
  int              dout_bad = 0, di_bad = 0;
  logic            prev_sclk = 1'b0, prev_dout = 1'b0, prev_load_n = 1'b1;
  logic            prev_rst = 1'b1, prev_fd = 1'b0;
  logic [0:N_IN-1] prev_di = '0;

  initial ser_din = 1'b0;

  always @(negedge clk) begin
    if (!ser_load_n && prev_load_n) begin
      stream.delete();
      rises = 0; falls = 0; load_cyc = 0; latch_cyc = 0;
    end
    if (!ser_load_n) load_cyc++;
    if (ser_latch) latch_cyc++;
    if (ser_clk && !prev_sclk) begin
      rises++;
      stream.push_back(ser_dout);
    end
    if (!ser_clk && prev_sclk) falls++;
    if (ser_dout !== prev_dout && !(prev_sclk && !ser_clk) &&
        !(!prev_load_n && ser_load_n) && !prev_rst) dout_bad++;
    if (device_inputs !== prev_di && !prev_fd && !prev_rst) di_bad++;
    // 165 chain: bit k is presented for the whole of serial bit k
    ser_din = (falls < int'(N_IN)) ? pat[falls] : 1'($urandom);
    prev_sclk   = ser_clk;
    prev_dout   = ser_dout;
    prev_load_n = ser_load_n;
    prev_rst    = reset;
    prev_fd     = frame_done;
    prev_di     = device_inputs;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic randomize_vectors();
    for (int i = 0; i < int'(N_OUT); i++) device_outputs[i] = 1'($urandom);
    for (int i = 0; i < int'(N_IN); i++) pat[i] = 1'($urandom);
  endtask

  // Runs one frame from IDLE; returns in the IDLE cycle after frame_done
  // (or right after raising reset when reset_at is hit).
  task automatic run_frame(input string tag, input int drop_at, input int flip_at,
                           input int reset_at);
    int cyc;
    logic [0:N_OUT-1] snap, got;
    snap   = device_outputs;
    enable = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    chk({tag, " busy_first"}, busy, 1);
    if (drop_at == 1) enable = 1'b0;
    while (!frame_done && cyc < 2 * FRAME_LEN) begin
      if (cyc == flip_at) device_outputs = ~device_outputs;
      if (cyc == reset_at) begin
        reset = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc == drop_at) enable = 1'b0;
    end
    if (reset_at != 0) return;
    chk({tag, " frame_len"}, cyc, FRAME_LEN);
    @(posedge clk); #1;
    chk({tag, " idle_after"}, {busy, frame_done, ser_clk, ser_latch, ser_load_n}, 5'b00001);
    chk({tag, " rises"}, rises, N_OUT);
    chk({tag, " load_width"}, load_cyc, CLK_DIV);
    chk({tag, " latch_width"}, latch_cyc, CLK_DIV);
    got = '0;
    for (int k = 0; k < stream.size() && k < int'(N_OUT); k++) got[N_OUT-1-k] = stream[k];
    chk({tag, " out_stream"}, got, snap);
    chk({tag, " device_inputs"}, device_inputs, pat);
    chk({tag, " di_stable"}, di_bad, 0);
    chk({tag, " dout_on_fall"}, dout_bad, 0);
  endtask

  initial begin
    reset          = 1'b1;
    enable         = 1'b1;
    device_outputs = '0;

    // Reset held with enable high
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("reset_busy", busy, 0);
    end
    chk("reset_pins", {ser_clk, ser_dout, ser_latch, ser_load_n, busy, frame_done}, 6'b000100);
    chk("reset_di", device_inputs, 0);
    reset  = 1'b0;
    enable = 1'b0;
    @(posedge clk); #1;

    // Alternating output pattern with a fixed input pattern
    device_outputs = {60{2'b10}};
    pat            = 60'hABC_DEF0_1234_5678;
    run_frame("alt", 1, 0, 0);

    // Changing device_outputs mid-SHIFT must not affect the frame
    device_outputs = {60{2'b10}};
    run_frame("flip", 1, CLK_DIV + 300, 0);

    for (int i = 0; i < 3; i++) begin
      randomize_vectors();
      run_frame("rnd", 1, 0, 0);
    end

    // Reset mid-frame clears everything, then a fresh frame runs
    randomize_vectors();
    run_frame("rst", 1, 0, 500);
    @(posedge clk); #1;
    chk("midrst_pins", {ser_clk, ser_dout, ser_latch, ser_load_n, busy, frame_done}, 6'b000100);
    chk("midrst_di", device_inputs, 0);
    reset = 1'b0;
    randomize_vectors();
    run_frame("post_rst", 1, 0, 0);

    // Back-to-back frames, then enable dropped mid-frame 4
    for (int i = 0; i < 3; i++) begin
      randomize_vectors();
      run_frame("held", 0, 0, 0);
    end
    randomize_vectors();
    run_frame("drop", 400, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stay_idle", {busy, ser_load_n}, 2'b01);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
